// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response and backdoor load signals of the instruction memory
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
interface imem_responder_if #(
  parameter int XLEN   = `XLEN,
  parameter int ADDR_W = `ADDR_W,
  parameter int DEPTH  = 1024
);
  logic                     mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic [XLEN-1:0]          mem_rdata;
  logic                     mem_ready;
  logic                     mem_err;
  logic                     ld_we;
  logic [$clog2(DEPTH)-1:0] ld_addr;
  logic [XLEN-1:0]          ld_data;
  modport master (
    output mem_req, mem_addr, ld_we, ld_addr, ld_data,
    input  mem_rdata, mem_ready, mem_err
  );
  modport slave (
    input  mem_req, mem_addr, ld_we, ld_addr, ld_data,
    output mem_rdata, mem_ready, mem_err
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with flush, redirect and backdoor loading
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
module imem_responder #(
  parameter int XLEN    = `XLEN,
  parameter int ADDR_W  = `ADDR_W,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            st_q, st_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              acc, bad;
  logic [IDX_W-1:0]  idx;
  logic [XLEN-1:0]   mem [DEPTH];
  // Next state: flush beats redirect beats countdown; WAIT enters RESP when the counter reaches 0
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    acc    = 1'b0;
    case (st_q)
      IDLE: acc = bus.mem_req;
      WAIT: begin
        if (!bus.mem_req) st_d = IDLE;
        else if (bus.mem_addr != addr_q) acc = 1'b1;
        else begin
          cnt_d = cnt_q - 4'd1;
          st_d  = (cnt_q == 4'd1) ? RESP : WAIT;
        end
      end
      RESP: begin
        acc  = bus.mem_req;
        st_d = bus.mem_req ? RESP : IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (acc) begin
      addr_d = bus.mem_addr;
      cnt_d  = LAT_M1;
      st_d   = (LATENCY == 1) ? RESP : WAIT;
    end
    idx = addr_d[IDX_W+1:2];
    bad = (addr_d[1:0] != 2'b00) || ((addr_d >> (IDX_W + 2)) != '0);
  end
  // Control state and response registers; response data is captured only on the edge entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      err_q  <= (st_d == RESP) && bad;
      if (st_d == RESP) rdata_q <= bad ? NOP : mem[idx];
    end
  end
  // Backdoor program load; storage survives reset but is write-protected while reset is held
  always_ff @(posedge clk) begin
    if (bus.ld_we && !rst) mem[bus.ld_addr] <= bus.ld_data;
  end
  assign bus.mem_ready = (st_q == RESP);
  assign bus.mem_err   = err_q;
  assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of latency, back-to-back, flush, redirect, errors and reset
module tb_imem_responder;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  imem_responder_if #(.XLEN(32), .ADDR_W(32), .DEPTH(1024)) bus ();
  imem_responder #(.XLEN(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic rdy, input logic err, input logic [31:0] data);
    n_chk++;
    assert (bus.mem_ready === rdy) else begin
      n_fail++;
      $error("FAIL %s ready: got %b expected %b", tag, bus.mem_ready, rdy);
    end
    n_chk++;
    assert (bus.mem_err === err) else begin
      n_fail++;
      $error("FAIL %s err: got %b expected %b", tag, bus.mem_err, err);
    end
    n_chk++;
    assert (bus.mem_rdata === data) else begin
      n_fail++;
      $error("FAIL %s rdata: got %h expected %h", tag, bus.mem_rdata, data);
    end
  endtask
  task automatic load(input int a, input logic [31:0] d);
    bus.ld_we = 1'b1;
    bus.ld_addr = 10'(a);
    bus.ld_data = d;
    tick();
    bus.ld_we = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.mem_req = 1'b0;
    bus.mem_addr = '0;
    bus.ld_we = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    tick();
    tick();
    chk("reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    load(0, 32'h0050_0093);
    load(1, 32'h0010_0113);
    load(2, 32'h0020_0193);
    load(3, 32'h0030_0213);
    load(4, 32'h0040_0293);
    load(5, 32'h1111_1111);
    chk("idle_after_load", 1'b0, 1'b0, 32'h0);
    // single request, latency 2
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h0;
    tick();
    chk("single_c1", 1'b0, 1'b0, 32'h0);
    tick();
    chk("single_c2", 1'b1, 1'b0, 32'h0050_0093);
    bus.mem_req = 1'b0;
    tick();
    chk("single_c3", 1'b0, 1'b0, 32'h0050_0093);
    // back-to-back stream 0x0, 0x4, 0x8
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h0;
    tick();
    chk("b2b_w0", 1'b0, 1'b0, 32'h0050_0093);
    tick();
    chk("b2b_r0", 1'b1, 1'b0, 32'h0050_0093);
    bus.mem_addr = 32'h4;
    tick();
    chk("b2b_w1", 1'b0, 1'b0, 32'h0050_0093);
    tick();
    chk("b2b_r1", 1'b1, 1'b0, 32'h0010_0113);
    bus.mem_addr = 32'h8;
    tick();
    chk("b2b_w2", 1'b0, 1'b0, 32'h0010_0113);
    tick();
    chk("b2b_r2", 1'b1, 1'b0, 32'h0020_0193);
    bus.mem_req = 1'b0;
    tick();
    chk("b2b_end", 1'b0, 1'b0, 32'h0020_0193);
    // flush one cycle after acceptance
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h4;
    tick();
    bus.mem_req = 1'b0;
    tick();
    chk("flush_c2", 1'b0, 1'b0, 32'h0020_0193);
    tick();
    chk("flush_c3", 1'b0, 1'b0, 32'h0020_0193);
    tick();
    chk("flush_c4", 1'b0, 1'b0, 32'h0020_0193);
    // redirect to 0x10 one cycle after acceptance of 0x4
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h4;
    tick();
    bus.mem_addr = 32'h10;
    tick();
    chk("redir_c1", 1'b0, 1'b0, 32'h0020_0193);
    tick();
    chk("redir_c2", 1'b1, 1'b0, 32'h0040_0293);
    bus.mem_req = 1'b0;
    tick();
    chk("redir_end", 1'b0, 1'b0, 32'h0040_0293);
    // misaligned, then out of range back-to-back, then a high address bit
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h2;
    tick();
    tick();
    chk("misalign", 1'b1, 1'b1, 32'h0000_0013);
    bus.mem_addr = 32'h1000;
    tick();
    chk("err_gap", 1'b0, 1'b0, 32'h0000_0013);
    tick();
    chk("out_of_range", 1'b1, 1'b1, 32'h0000_0013);
    bus.mem_addr = 32'h8000_0000;
    tick();
    tick();
    chk("high_bit", 1'b1, 1'b1, 32'h0000_0013);
    bus.mem_addr = 32'hC;
    tick();
    tick();
    chk("ok_after_err", 1'b1, 1'b0, 32'h0030_0213);
    bus.mem_addr = 32'h2;
    tick();
    tick();
    chk("misalign2", 1'b1, 1'b1, 32'h0000_0013);
    bus.mem_req = 1'b0;
    tick();
    // reset in WAIT, with a load attempted during reset
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h14;
    tick();
    rst = 1'b1;
    bus.ld_we = 1'b1;
    bus.ld_addr = 10'd5;
    bus.ld_data = 32'hDEAD_BEEF;
    tick();
    chk("rst_wait", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    bus.ld_we = 1'b0;
    bus.mem_req = 1'b0;
    tick();
    chk("post_rst1", 1'b0, 1'b0, 32'h0);
    tick();
    chk("post_rst2", 1'b0, 1'b0, 32'h0);
    tick();
    chk("post_rst3", 1'b0, 1'b0, 32'h0);
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h14;
    tick();
    tick();
    chk("word5_kept", 1'b1, 1'b0, 32'h1111_1111);
    bus.mem_addr = 32'h0;
    tick();
    tick();
    chk("word0_kept", 1'b1, 1'b0, 32'h0050_0093);
    bus.mem_req = 1'b0;
    tick();
    // load colliding with the response-capture edge returns old data
    bus.mem_req = 1'b1;
    bus.mem_addr = 32'h4;
    tick();
    bus.ld_we = 1'b1;
    bus.ld_addr = 10'd1;
    bus.ld_data = 32'hCAFE_F00D;
    tick();
    chk("wr_collide_old", 1'b1, 1'b0, 32'h0010_0113);
    bus.ld_we = 1'b0;
    tick();
    tick();
    chk("wr_collide_new", 1'b1, 1'b0, 32'hCAFE_F00D);
    bus.mem_req = 1'b0;
    tick();
    chk("final_idle", 1'b0, 1'b0, 32'hCAFE_F00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter XLEN, default `XLEN (32), data width of mem_rdata and the storage words.
REQ-002 Parameter ADDR_W, default `ADDR_W (32), width of mem_addr.
REQ-003 Parameter DEPTH, default 1024, number of XLEN-bit words stored; a power of two.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to mem_ready; legal range 1..15.
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port rst  input  1  reset, synchronous and active-high.
REQ-007 Port mem_req  input  1  fetch request, level, held by the requester until mem_ready or a flush.
REQ-008 Port mem_addr  input  ADDR_W  byte address of the requested instruction.
REQ-009 Port mem_rdata  output  XLEN  returned instruction word; valid only while mem_ready=1.
REQ-010 Port mem_ready  output  1  one-cycle pulse marking the response cycle.
REQ-011 Port mem_err  output  1  qualifies mem_ready: the access was misaligned or out of range.
REQ-012 Port ld_we  input  1  backdoor word-write enable for program loading.
REQ-013 Port ld_addr  input  $clog2(DEPTH)  backdoor word index.
REQ-014 Port ld_data  input  XLEN  backdoor write data.

Function
REQ-015 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 IDLE with mem_req=1 SHALL accept the request at the clock edge: latch mem_addr, load the counter with LATENCY-1, then go to WAIT, or go directly to RESP when LATENCY=1.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-018 The response SHALL occur exactly LATENCY cycles after the acceptance edge; mem_ready=1 for exactly one cycle, in RESP.
REQ-019 mem_rdata and mem_err SHALL be registered on the edge entering RESP, using the array contents and latched address at that edge.
REQ-020 Word index = latched address bits [$clog2(DEPTH)+1:2].
REQ-021 Error condition: address bits [1:0] != 0, or any address bit above the index field set. On error, mem_err=1, mem_rdata=32'h0000_0013 (NOP), and the array is not read.
REQ-022 Flush: mem_req=0 sampled in WAIT SHALL abort the request, return the FSM to IDLE, and produce no mem_ready.
REQ-023 Redirect: in WAIT, mem_addr != latched address with mem_req=1 SHALL restart acceptance with the new address; the counter reloads to LATENCY-1, and the full LATENCY applies from that edge.
REQ-024 Back-to-back: in RESP, mem_req=1 SHALL be accepted as a new request on that edge, following the REQ-016 transitions, so consecutive responses are LATENCY cycles apart.
REQ-025 RESP with mem_req=0 SHALL return the FSM to IDLE.
REQ-026 Outside RESP, mem_ready=0 and mem_err=0; mem_rdata holds its last value.
REQ-027 ld_we=1 SHALL write ld_data to word ld_addr at the edge, in any FSM state.
REQ-028 A load to the same word on the edge that registers mem_rdata SHALL return the old contents; the new value is visible to later responses.
REQ-029 mem_rdata SHALL be a pure function of registered state; there is no combinational path from mem_req or mem_addr to the outputs.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, counter=0, latched address=0, mem_ready=0, mem_err=0, mem_rdata=0, overriding all other inputs.
REQ-031 Reset mid-request, in WAIT or RESP, SHALL discard the request; no mem_ready appears after reset deasserts until a new acceptance plus LATENCY cycles.
REQ-032 Reset SHALL NOT clear the storage array; ld_we writes SHALL be ignored while rst=1.

Verification
REQ-033 LATENCY=2: load word 0 = 0x00500093 via ld_we; assert mem_req with addr 0x0 at cycle 0 -> mem_ready=1, mem_rdata=0x00500093, mem_err=0 in cycle 2 only.
REQ-034 Requests to 0x0, 0x4 and 0x8 with mem_req held and addr updated on each mem_ready -> three ready pulses exactly 2 cycles apart, returning words 0, 1 and 2 in order.
REQ-035 Request 0x4 accepted, then mem_req=0 the next cycle -> no mem_ready; FSM in IDLE.
REQ-036 Request 0x4 accepted, addr changed to 0x10 one cycle later -> single mem_ready 2 cycles after the change, with word 4 data.
REQ-037 addr=0x2 -> mem_err=1, mem_rdata=0x00000013; addr=4*DEPTH -> mem_err=1, mem_rdata=0x00000013.
REQ-038 rst=1 in WAIT -> outputs zero next cycle, no stale ready afterwards; previously loaded words still read back correctly.
